cpu_sequencer: RTL

//  Fetch/decode/execute controller for the 8-bit soft CPU. Owns the PC and IR and drives the

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/cpu_pc.sv | 39 +++
 rtl/cpu_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit soft CPU sequencer: opcodes, FSM states and A-source selects.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_e;

    localparam logic [1:0] ASEL_MEM = 2'd0;
    localparam logic [1:0] ASEL_IMM = 2'd1;
    localparam logic [1:0] ASEL_ALU = 2'd2;

endpackage

// File: rtl/cpu_pc.sv
// Program counter: ADDR_W-bit register with increment and parallel load; load wins over increment.
module cpu_pc #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next-PC selection; the increment wraps naturally at 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller owning PC and IR; drives datapath load strobes as Moore outputs.
// Optional single-step gating of FETCH is enabled with CPU_SEQ_STEP_EN.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              zero_flag,
`ifdef CPU_SEQ_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              a_en,
    output logic              b_en,
    output logic              out_en,
    output logic [1:0]        a_sel,
    output logic [DATA_W-1:0] imm,
    output logic              alu_sub,
    output logic              halted
);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ir_d;
    logic              step_ok_s;
    logic              pc_inc_s;
    logic              pc_load_s;
    logic [3:0]        opcode_s;
    logic [ADDR_W-1:0] operand_s;

`ifdef CPU_SEQ_STEP_EN
    assign step_ok_s = step;
`else
    assign step_ok_s = 1'b1;
`endif

    assign opcode_s  = ir_q[DATA_W-1:DATA_W-4];
    assign operand_s = ADDR_W'(ir_q[3:0]);
    assign imm       = DATA_W'(ir_q[3:0]);

    cpu_pc #(
        .ADDR_W(ADDR_W)
    ) u_pc (
        .clk_i      (clk),
        .rst_ni     (reset),
        .inc_i      (pc_inc_s),
        .load_i     (pc_load_s),
        .load_val_i (operand_s),
        .pc_o       (pc)
    );

    // Next state, IR capture and PC control.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_inc_s  = 1'b0;
        pc_load_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (step_ok_s) begin
                    state_d  = S_DECODE;
                    ir_d     = mem_rdata;
                    pc_inc_s = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (opcode_s == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
                if (opcode_s == OP_JMP) begin
                    pc_load_s = 1'b1;
                end else if (opcode_s == OP_JZ) begin
                    pc_load_s = zero_flag;
                end else begin
                    pc_load_s = 1'b0;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and instruction registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Moore output decode from registered state and IR.
    always_comb begin
        mem_addr = pc;
        a_en     = 1'b0;
        b_en     = 1'b0;
        out_en   = 1'b0;
        a_sel    = ASEL_MEM;
        alu_sub  = 1'b0;
        halted   = (state_q == S_HALT);
        if (state_q == S_EXECUTE) begin
            case (opcode_s)
                OP_LDA: begin
                    mem_addr = operand_s;
                    a_en     = 1'b1;
                    a_sel    = ASEL_MEM;
                end
                OP_LDB: begin
                    mem_addr = operand_s;
                    b_en     = 1'b1;
                end
                OP_ADD: begin
                    a_en  = 1'b1;
                    a_sel = ASEL_ALU;
                end
                OP_SUB: begin
                    a_en    = 1'b1;
                    a_sel   = ASEL_ALU;
                    alu_sub = 1'b1;
                end
                OP_OUT: begin
                    out_en = 1'b1;
                end
                OP_LDI: begin
                    a_en  = 1'b1;
                    a_sel = ASEL_IMM;
                end
                default: begin
                    a_en = 1'b0;
                end
            endcase
        end else begin
            a_en = 1'b0;
        end
    end

endmodule
